// File: rtl/hamm_pkg.sv
// Shared helpers for the hamm_* encoder/decoder family: code geometry
// functions and the common error-class enum.
package hamm_pkg;

  typedef enum logic [1:0] {CLEAN, SINGLE, DOUBLE} err_class_e;

  // Smallest P with 2^P >= dw + P + 1.
  function automatic int par_width(input int dw);
    int p;
    p = 0;
    for (int k = 8; k >= 1; k--)
      if ((1 << k) >= dw + k + 1) p = k;
    return p;
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Code index (0-based, position-1) of data bit i.
  function automatic int data_pos(input int i);
    int cnt;
    int r;
    cnt = 0;
    r   = 0;
    for (int pos = 1; pos < 128; pos++) begin
      if (!is_pow2(pos)) begin
        if (cnt == i) r = pos - 1;
        cnt++;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hamm_syndrome.sv
// Combinational Hamming syndrome: XOR of the 1-based positions of all set bits.
module hamm_syndrome #(
  parameter int CODE_WIDTH = 12,
  parameter int PAR_WIDTH  = 4
) (
  input  logic [CODE_WIDTH-1:0] code,
  output logic [PAR_WIDTH-1:0]  syn
);

  always_comb begin
    syn = '0;
    for (int i = 0; i < CODE_WIDTH; i++)
      if (code[i]) syn = syn ^ PAR_WIDTH'(i + 1);
  end

endmodule

// File: rtl/hamm_secded_dec.sv
// Two-stage streaming SECDED decoder with valid/ready back-pressure and
// saturating corrected/uncorrectable beat counters.
module hamm_secded_dec
  import hamm_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  CNT_WIDTH  = 16,
  localparam int PAR_WIDTH  = par_width(DATA_WIDTH),
  localparam int CODE_WIDTH = DATA_WIDTH + PAR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CODE_WIDTH-1:0] code_in,
  input  logic                  par_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [PAR_WIDTH-1:0]  syndrome,
  output logic                  err_single,
  output logic                  err_double,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  clear_cnt,
  output logic [CNT_WIDTH-1:0]  corr_cnt,
  output logic [CNT_WIDTH-1:0]  uncorr_cnt
);

  logic [2:1]            vld_pipe;
  logic                  adv1, adv2;
  logic [CODE_WIDTH-1:0] code1, fixed;
  logic [PAR_WIDTH-1:0]  syn_c, syn1;
  logic                  par1;
  logic [DATA_WIDTH-1:0] data_c;
  err_class_e            cls;

  assign adv2      = !vld_pipe[2] || out_ready;
  assign adv1      = !vld_pipe[1] || adv2;
  assign in_ready  = rst_n && adv1;
  assign out_valid = vld_pipe[2];

  hamm_syndrome #(.CODE_WIDTH(CODE_WIDTH), .PAR_WIDTH(PAR_WIDTH)) u_syn (
    .code (code_in),
    .syn  (syn_c)
  );

  // Syndromes beyond the code length name a nonexistent bit: uncorrectable.
  always_comb begin
    fixed  = code1;
    data_c = '0;
    if (syn1 == '0)                                   cls = par1 ? SINGLE : CLEAN;
    else if (par1 && (int'(syn1) <= CODE_WIDTH))      cls = SINGLE;
    else                                              cls = DOUBLE;
    for (int i = 0; i < CODE_WIDTH; i++)
      if (par1 && (int'(syn1) == i + 1)) fixed[i] = !fixed[i];
    for (int i = 0; i < DATA_WIDTH; i++)
      data_c[i] = fixed[data_pos(i)];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe   <= '0;
      code1      <= '0;
      syn1       <= '0;
      par1       <= 1'b0;
      data_out   <= '0;
      syndrome   <= '0;
      err_single <= 1'b0;
      err_double <= 1'b0;
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else begin
      if (adv1) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) begin
          code1 <= code_in;
          syn1  <= syn_c;
          par1  <= ^code_in ^ par_in;
        end
      end
      if (adv2) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          data_out   <= data_c;
          syndrome   <= syn1;
          err_single <= (cls == SINGLE);
          err_double <= (cls == DOUBLE);
        end
      end
      if (clear_cnt) begin
        corr_cnt   <= '0;
        uncorr_cnt <= '0;
      end else if (vld_pipe[2] && out_ready) begin
        if (err_single && (corr_cnt != '1))   corr_cnt   <= corr_cnt + 1'b1;
        if (err_double && (uncorr_cnt != '1)) uncorr_cnt <= uncorr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/hamm_secded_dec.md
Name: hamm_secded_dec

Overview:
Streaming, parametrised SECDED Hamming decoder and the receive-side companion of the hamm_enc encoder family. It accepts a Hamming codeword plus an overall even-parity bit over a valid/ready handshake. It corrects single-bit errors, flags double or uncorrectable errors, and keeps saturating error counters for status readout. The pipeline has two register stages and supports full back-pressure.

Parameters:
- DATA_WIDTH, 8: payload bits. Range 4..57.
- PAR_WIDTH, derived: smallest P with 2^P >= DATA_WIDTH+P+1. Equals 4 for DATA_WIDTH=8.
- CODE_WIDTH, derived: DATA_WIDTH+PAR_WIDTH. Equals 12 for DATA_WIDTH=8.
- CNT_WIDTH, 16: width of each error counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- code_in  in  CODE_WIDTH  codeword. Bit i holds Hamming position i+1.
- par_in  in  1  overall even parity over code_in, as produced by the encoder.
- in_valid  in  1  input beat valid.
- in_ready  out  1  decoder can accept a beat.
- data_out  out  DATA_WIDTH  corrected payload.
- syndrome  out  PAR_WIDTH  raw syndrome of the beat.
- err_single  out  1  single error detected and corrected (or error in the parity bit only).
- err_double  out  1  uncorrectable error. data_out is passed through uncorrected.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- clear_cnt  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_WIDTH  count of beats with err_single, saturating.
- uncorr_cnt  out  CNT_WIDTH  count of beats with err_double, saturating.

Behaviour:
- Reset: clk and rst_n are the only clock and reset; reset is synchronous and active-low.
  - While rst_n=0: every register clears, out_valid=0, in_ready=0, data_out=0, syndrome=0, err_*=0, both counters=0.
  - A reset mid-operation discards all in-flight beats.
- Code layout:
  - Parity bits sit at power-of-two positions 1, 2, 4, 8, ...
  - Data bit 0 goes to the lowest non-power-of-two position, then data fills upward in order.
  - Parity bit at position 2^k is the even parity of all positions with bit k set.
- Stage 1 (register): capture code_in, syndrome s = XOR of the positions of all set bits, and p = XOR(code_in)^par_in.
- Stage 2 (register): classify and correct, then drive the outputs.
  - s=0, p=0: clean. No flags.
  - s=0, p=1: error in the overall parity bit. err_single=1, data unchanged.
  - s in 1..CODE_WIDTH, p=1: flip code bit s-1, then extract data. err_single=1.
  - s>CODE_WIDTH, p=1: position does not exist. err_double=1, no flip.
  - s!=0, p=0: double error. err_double=1, no flip.
- Latency: 2 cycles from the input handshake to out_valid, when there is no stall.
- Handshake:
  - adv2 = !v2 | out_ready; adv1 = !v1 | adv2; in_ready = adv1 (combinational from out_ready).
  - A beat transfers on valid&ready.
  - Full throughput is 1 beat/cycle.
  - While a stage is stalled, its contents and all outputs hold stable.
- Counters:
  - Increment once per output handshake (out_valid&out_ready) carrying err_single or err_double respectively.
  - Both saturate at all-ones.
  - If clear_cnt and an increment occur in the same cycle, clear wins.
- Outputs in an empty slot: when out_valid=0, data_out, syndrome and err_* hold their last values. The bench must not check them.

Decomposition:
- hamm_pkg holds:
  - function par_width(dw);
  - function is_pow2(pos);
  - function data_pos(i), which returns the code index of data bit i;
  - a shared error-class enum {CLEAN, SINGLE, DOUBLE}.
  - The encoder family uses the same package.
- One sub-module, hamm_syndrome: combinational, computes the PAR_WIDTH syndrome from a CODE_WIDTH word. The next-generation encoder reuses it.

Test Plan:
1. Clean beat: code_in=12'hC21, par_in=0 -> 2 cycles later data_out=8'hC4, syndrome=0, err_single=0, err_double=0. Counters stay 0.
2. Single data-bit error: code_in=12'hC01, par_in=0 -> syndrome=6, data_out=8'hC4, err_single=1. corr_cnt=1.
3. Parity-bit-only error, then double error:
   - code_in=12'hC21, par_in=1 -> err_single=1, syndrome=0, data_out=8'hC4.
   - Then code_in=12'hC00, par_in=0 -> syndrome=7, err_double=1, data_out=8'hC0. uncorr_cnt=1.
4. Out-of-range syndrome: code_in=12'hCA8, par_in=0 -> syndrome=13, err_double=1, no flip, data_out=8'hC4.
5. Back-pressure:
   - Stream 4 clean beats with out_ready=0 -> in_ready drops after 2 accepted; outputs hold stable.
   - Then raise out_ready -> all 4 beats emerge in order with no loss or duplication.
   - Pulse rst_n=0 mid-stream -> out_valid=0 next cycle; pending beats are dropped.
6. Counter saturation and clear, with CNT_WIDTH=2:
   - Send 5 single-error beats -> corr_cnt sticks at 3.
   - Assert clear_cnt in the same cycle as a 6th error handshake -> corr_cnt=0.
